mem_copy_engine: RTL and testbench

- Bus initiator that drives the single-port word data memory (Address / WE / WD in, ReadData out): performs block copy or block fill without CPU involvement.
- Sits beside the core on the data-memory port; a mux outside this block selects core vs engine while Busy=1.
- The memory has combinational read and a write on the posedge, so the engine reads one cycle and writes the next.

---
 rtl/mem_copy_pkg.sv | 22 ++
 rtl/mem_copy_addr_gen.sv | 77 +++++++
 rtl/mem_copy_engine.sv | 151 +++++++++++++++
 tb/tb_mem_copy_engine.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg
//   Shared definitions for the memory copy/fill engine: FSM state encoding,
//   mode encoding and default widths for the data-memory word index and the
//   transfer length.
package mem_copy_pkg;

  // 128-word data memory; the length is one bit wider so a full-memory
  // transfer (128 words) can be requested.
  localparam int ADDR_W_DEF = 7;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// mem_copy_addr_gen
//   Holds the latched source/destination base addresses, the transfer length
//   and the running word index i. Produces wrapped addresses (base+i) and a
//   flag marking the last word of the transfer.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture src_in/dst_in/len_in and clear i
//   step         advance i by one (one word written)
//   src_in       source base word index
//   dst_in       destination base word index
//   len_in       number of words in the transfer
//   src_addr     (src + i) mod 2^ADDR_W
//   dst_addr     (dst + i) mod 2^ADDR_W
//   idx          current index i (= words written so far)
//   last         i + 1 == len
module mem_copy_addr_gen #(
  parameter int ADDR_W = 7,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [LEN_W-1:0]  idx,
  output logic              last
);

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    idx_d = idx_q;
    if (load) begin
      src_d = src_in;
      dst_d = dst_in;
      len_d = len_in;
      idx_d = '0;
    end else if (step) begin
      idx_d = idx_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      idx_q <= idx_d;
    end
  end

  // Addresses wrap naturally in ADDR_W bits; only the low bits of i matter,
  // which also makes lengths above 2^ADDR_W wrap around the memory.
  assign src_addr = src_q + idx_q[ADDR_W-1:0];
  assign dst_addr = dst_q + idx_q[ADDR_W-1:0];
  assign idx      = idx_q;

  // Compared one bit wider so i+1 cannot overflow back to zero.
  assign last = (({1'b0, idx_q}) + (LEN_W+1)'(1)) == {1'b0, len_q};

endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Bus initiator on the single-port data memory. Copies a block of words
//   (read one cycle, write the next) or fills a block with a pattern (one
//   write per cycle) without CPU involvement. The memory reads
//   combinationally and writes on the rising edge.
//
// Ports:
//   CLK, RESETn   clock, asynchronous active-low reset
//   Start         transfer request, sampled only in IDLE
//   Mode          0 = copy, 1 = fill
//   SrcAddr       source word index (low ADDR_W bits used, copy only)
//   DstAddr       destination word index (low ADDR_W bits used)
//   Len           number of words
//   FillData      pattern written in fill mode
//   Busy          high while reading/writing (RD or WR state)
//   Done          one-cycle completion pulse
//   WordCount     words written in the current or last transfer
//   MemAddress    memory word address (upper bits always 0)
//   MemWE         memory write enable
//   MemWD         memory write data
//   MemReadData   memory read data, combinational from MemAddress
//
// All memory-side outputs decode from registered state only, so request
// inputs never reach the memory bus combinationally.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             Mode,
  input  logic [31:0]      SrcAddr,
  input  logic [31:0]      DstAddr,
  input  logic [LEN_W-1:0] Len,
  input  logic [31:0]      FillData,
  output logic             Busy,
  output logic             Done,
  output logic [LEN_W-1:0] WordCount,
  output logic [31:0]      MemAddress,
  output logic             MemWE,
  output logic [31:0]      MemWD,
  input  logic [31:0]      MemReadData
);

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic [31:0] fill_q, fill_d;
  logic [31:0] buf_q, buf_d;

  logic              load;
  logic              step;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic              last;

  // Upper address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{SrcAddr[31:ADDR_W], DstAddr[31:ADDR_W]};

  assign load = (state_q == ST_IDLE) && Start;
  assign step = (state_q == ST_WR);

  mem_copy_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk      (CLK),
    .rst_n    (RESETn),
    .load     (load),
    .step     (step),
    .src_in   (SrcAddr[ADDR_W-1:0]),
    .dst_in   (DstAddr[ADDR_W-1:0]),
    .len_in   (Len),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .idx      (WordCount),
    .last     (last)
  );

  // State register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COPY;
      fill_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          mode_d = Mode;
          fill_d = FillData;
          if (Len == '0)             state_d = ST_DONE;
          else if (Mode == MODE_FILL) state_d = ST_WR;
          else                        state_d = ST_RD;
        end
      end
      ST_RD: begin
        buf_d   = MemReadData;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (last)                     state_d = ST_DONE;
        else if (mode_q == MODE_FILL) state_d = ST_WR;
        else                          state_d = ST_RD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    Busy       = 1'b0;
    Done       = 1'b0;
    MemWE      = 1'b0;
    MemAddress = '0;
    MemWD      = '0;
    unique case (state_q)
      ST_RD: begin
        Busy       = 1'b1;
        MemAddress = {{(32-ADDR_W){1'b0}}, src_addr};
      end
      ST_WR: begin
        Busy       = 1'b1;
        MemWE      = 1'b1;
        MemAddress = {{(32-ADDR_W){1'b0}}, dst_addr};
        MemWD      = (mode_q == MODE_FILL) ? fill_q : buf_q;
      end
      ST_DONE: Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine
//   Self-checking bench: behavioural 128-word memory, expected-write queue
//   filled from a shadow memory model when a transfer is launched, latency /
//   write-cycle / word-count checks per transfer, and a final report.
module tb_mem_copy_engine;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESETn;
  always #5 CLK = ~CLK;

  logic        Start, Mode;
  logic [31:0] SrcAddr, DstAddr, FillData;
  logic [7:0]  Len;
  logic        Busy, Done, MemWE;
  logic [7:0]  WordCount;
  logic [31:0] MemAddress, MemWD, MemReadData;

  mem_copy_engine dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .Start       (Start),
    .Mode        (Mode),
    .SrcAddr     (SrcAddr),
    .DstAddr     (DstAddr),
    .Len         (Len),
    .FillData    (FillData),
    .Busy        (Busy),
    .Done        (Done),
    .WordCount   (WordCount),
    .MemAddress  (MemAddress),
    .MemWE       (MemWE),
    .MemWD       (MemWD),
    .MemReadData (MemReadData)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [128];
  logic [31:0] shadow [128];
  logic        mem_init = 1'b0;

  function automatic logic [31:0] init_word(int k);
    return (k < 16) ? 32'(k) : (32'hC0DE_0000 | 32'(k));
  endfunction

  assign MemReadData = mem[MemAddress[6:0]];

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int k = 0; k < 128; k++) mem[k] <= init_word(k);
    end else if (MemWE) begin
      mem[MemAddress[6:0]] <= MemWD;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- scoreboard ----------------
  logic [38:0] exp_q [$];
  bit          sb_en = 1'b1;

  always @(negedge CLK) begin
    if (sb_en && MemWE) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {MemAddress, MemWD}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [38:0] e;
        e = exp_q.pop_front();
        check("wr", {MemAddress, MemWD}, {25'b0, e[38:32], e[31:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic init_mem();
    @(negedge CLK);
    mem_init = 1'b1;
    @(negedge CLK);
    mem_init = 1'b0;
    for (int k = 0; k < 128; k++) shadow[k] = init_word(k);
  endtask

  task automatic check_mem_image(input string tag);
    int mism = 0;
    for (int k = 0; k < 128; k++) if (mem[k] !== shadow[k]) mism++;
    check(tag, 64'(mism), 64'd0);
  endtask

  // Launch one transfer and follow it to Done. src/dst are full 32-bit
  // values; the model uses only their low 7 bits.
  task automatic run_xfer(input bit mode, input logic [31:0] src, input logic [31:0] dst,
                          input int len, input logic [31:0] fill, input bit glitch);
    int          exp_done;
    logic [63:0] exp_mask, got_mask;
    logic [6:0]  a;
    logic [31:0] d;
    int          cyc;
    bit          done_seen;

    exp_done = (len == 0) ? 1 : (mode ? len + 1 : 2 * len + 1);
    exp_mask = '0;
    for (int c = 1; c < exp_done && c < 64; c++) if (mode || (c % 2 == 0)) exp_mask[c] = 1'b1;

    // Expected writes, in order, using the shadow so overlap is modelled.
    for (int k = 0; k < len; k++) begin
      a = 7'(int'(dst[6:0]) + k);
      d = mode ? fill : shadow[7'(int'(src[6:0]) + k)];
      shadow[a] = d;
      exp_q.push_back({a, d});
    end

    @(negedge CLK);
    Start = 1'b1; Mode = mode; SrcAddr = src; DstAddr = dst;
    Len = 8'(len); FillData = fill;
    @(posedge CLK);
    #1;
    // Inputs after acceptance must not matter.
    Start = 1'b0; Mode = ~mode; SrcAddr = $urandom; DstAddr = $urandom;
    Len = 8'($urandom_range(0, 255)); FillData = $urandom;

    cyc = 0; done_seen = 1'b0; got_mask = '0;
    while (cyc < 600) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1 && len > 0) check("busy_c1", 64'(Busy), 64'd1);
      if (MemWE && cyc < 64) got_mask[cyc] = 1'b1;
      if (glitch && cyc == 3) begin
        Start = 1'b1; Mode = 1'b1; DstAddr = 32'd99; Len = 8'd5;
      end
      if (glitch && cyc == 4) Start = 1'b0;
      if (Done) begin
        done_seen = 1'b1;
        break;
      end
    end
    check("done_lat", done_seen ? 64'(cyc) : 64'd0, 64'(exp_done));
    check("we_cycles", got_mask, exp_mask);
    check("busy_at_done", 64'(Busy), 64'd0);
    check("wcount", 64'(WordCount), 64'(len & 255));
    @(negedge CLK);
    check("done_pulse", 64'(Done), 64'd0);
    check("wcount_hold", 64'(WordCount), 64'(len & 255));
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check_mem_image("mem_img");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESETn = 1'b0; Start = 1'b0; Mode = 1'b0; SrcAddr = '0; DstAddr = '0;
    Len = '0; FillData = '0;
    init_mem();
    @(negedge CLK);
    check("rst_busy",  64'(Busy), 64'd0);
    check("rst_done",  64'(Done), 64'd0);
    check("rst_we",    64'(MemWE), 64'd0);
    check("rst_addr",  64'(MemAddress), 64'd0);
    check("rst_wd",    64'(MemWD), 64'd0);
    check("rst_wcount", 64'(WordCount), 64'd0);
    RESETn = 1'b1;
    @(negedge CLK);

    // Plan transfers
    run_xfer(1'b0, 32'd0,  32'd32,  4, 32'h0,         1'b0);  // copy
    check("copy_m35", 64'(mem[35]), 64'd3);
    run_xfer(1'b1, 32'd0,  32'd64,  3, 32'hDEADBEEF,  1'b0);  // fill
    check("fill_m67", 64'(mem[67]), 64'(init_word(67)));
    run_xfer(1'b0, 32'd5,  32'd20,  0, 32'h0,         1'b0);  // Len=0
    run_xfer(1'b1, 32'd0,  32'd126, 4, 32'hA5,        1'b0);  // wrap
    check("wrap_m0", 64'(mem[0]), 64'hA5);
    run_xfer(1'b0, 32'd2,  32'd48,  4, 32'h0,         1'b1);  // busy interlock
    run_xfer(1'b0, 32'hFFFF_FF02, 32'h1234_5604, 6, 32'h0, 1'b0); // overlap, high bits
    run_xfer(1'b1, 32'd0,  32'd100, 200, 32'h5A5A_0F0F, 1'b0); // Len > 128
    run_xfer(1'b0, 32'd120, 32'd10, 130, 32'h0,       1'b0);  // long wrapping copy
    for (int r = 0; r < 4; r++)
      run_xfer(1'($urandom_range(0, 1)), $urandom, $urandom,
               $urandom_range(0, 40), $urandom, 1'b0);

    // Reset mid-copy during the second write cycle
    init_mem();
    sb_en = 1'b0;
    @(negedge CLK);
    Start = 1'b1; Mode = 1'b0; SrcAddr = 32'd0; DstAddr = 32'd32; Len = 8'd4;
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (4) @(negedge CLK);
    check("pre_rst_we", 64'(MemWE), 64'd1);
    check("pre_rst_addr", 64'(MemAddress), 64'd33);
    #2 RESETn = 1'b0;
    #1;
    check("rst_mid_we", 64'(MemWE), 64'd0);
    check("rst_mid_busy", 64'(Busy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("rst_no_done", 64'(Done), 64'd0);
    end
    RESETn = 1'b1;
    shadow[32] = 32'd0;
    check_mem_image("rst_mem_img");
    check("rst_m32", 64'(mem[32]), 64'd0);
    check("rst_m34", 64'(mem[34]), 64'(init_word(34)));
    sb_en = 1'b1;
    run_xfer(1'b1, 32'd0, 32'd40, 2, 32'hCAFE_F00D, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
